// File: rtl/fft_pkg.sv
// Shared constants and types for the 512-point FFT datapath (feeder, step1 and later stages).
package fft_pkg;
  localparam int FIX    = 10;
  localparam int LANES  = 16;
  localparam int N      = 256;
  localparam int DEPTH  = N / LANES;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(2 * DEPTH);
  localparam int VEC_W  = LANES * FIX;
  localparam int WORD_W = 2 * VEC_W;

  typedef logic signed [FIX-1:0] sample_t;
  typedef sample_t [0:LANES-1] lane_vec_t;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } feed_state_t;

  // One buffer word holds a whole beat: real lanes in the upper half, imaginary in the lower.
  function automatic logic [WORD_W-1:0] pack_beat(input logic [VEC_W-1:0] re,
                                                  input logic [VEC_W-1:0] im);
    return {re, im};
  endfunction
endpackage

// File: rtl/fft_half_frame_buf.sv
// Half-frame store: DEPTH beats of LANES complex samples, one write port and a registered read port.
module fft_half_frame_buf
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read data holds between reads so the pair outputs keep their last value while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_in_pair_buffer.sv
// Buffers the first half-frame and emits aligned x[n] / x[n+N] butterfly pairs for step1.
module fft_in_pair_buffer
  import fft_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [0:LANES-1][FIX-1:0]   din_re,
  input  logic [0:LANES-1][FIX-1:0]   din_im,
  output logic                        valid,
  output logic [0:LANES-1][FIX-1:0]   p_bfly00_re,
  output logic [0:LANES-1][FIX-1:0]   p_bfly00_im,
  output logic [0:LANES-1][FIX-1:0]   n_bfly00_re,
  output logic [0:LANES-1][FIX-1:0]   n_bfly00_im,
  output logic [IDX_W-1:0]            pair_idx,
  output logic                        frame_done
);
  feed_state_t         r_state, w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    w_slot;
  logic                w_we, w_pair;
  logic [WORD_W-1:0]   w_rdata;
  logic                r_valid, r_done;
  logic [IDX_W-1:0]    r_idx;
  logic [VEC_W-1:0]    r_n_re, r_n_im;

  // DEPTH is a power of two, so the low bits give both the fill address and j = cnt-DEPTH.
  assign w_slot = r_cnt[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (in_valid) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_pair       = 1'b0;
    case (r_state)
      FILL: begin
        if (in_valid) begin
          w_we = 1'b1;
          if (r_cnt == CNT_W'(DEPTH - 1)) w_next_state = PAIR;
        end
      end
      PAIR: begin
        if (in_valid) begin
          w_pair = 1'b1;
          if (r_cnt == CNT_W'(2 * DEPTH - 1)) w_next_state = FILL;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  fft_half_frame_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_slot),
    .i_wdata (pack_beat(din_re, din_im)),
    .i_re    (w_pair),
    .i_raddr (w_slot),
    .o_rdata (w_rdata)
  );

  // The buffer read and these registers share the same edge, keeping p and n aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_n_re  <= '0;
      r_n_im  <= '0;
    end else begin
      r_valid <= w_pair;
      r_done  <= w_pair && (w_slot == IDX_W'(DEPTH - 1));
      if (w_pair) begin
        r_idx  <= w_slot;
        r_n_re <= din_re;
        r_n_im <= din_im;
      end
    end
  end

  assign valid       = r_valid;
  assign frame_done  = r_done;
  assign pair_idx    = r_idx;
  assign p_bfly00_re = w_rdata[WORD_W-1 -: VEC_W];
  assign p_bfly00_im = w_rdata[VEC_W-1:0];
  assign n_bfly00_re = r_n_re;
  assign n_bfly00_im = r_n_im;
endmodule

// File: tb/tb_fft_in_pair_buffer.sv
// Bench for fft_in_pair_buffer: frame-level reference model of the pairing rule x[n] / x[n+N].
module tb_fft_in_pair_buffer;
  import fft_pkg::*;

  typedef logic [0:LANES-1][FIX-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  vec_t             din_re, din_im;
  logic             valid;
  vec_t             p_bfly00_re, p_bfly00_im, n_bfly00_re, n_bfly00_im;
  logic [IDX_W-1:0] pair_idx;
  logic             frame_done;

  int errors = 0;
  int checks = 0;

  // Reference model: one whole 2N-sample frame plus the expected output registers.
  logic [FIX-1:0]   xr [2*N];
  logic [FIX-1:0]   xi [2*N];
  int               m_beat;
  logic             e_valid, e_done;
  logic [IDX_W-1:0] e_idx;
  vec_t             e_pr, e_pi, e_nr, e_ni;

  fft_in_pair_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .din_re      (din_re),
    .din_im      (din_im),
    .valid       (valid),
    .p_bfly00_re (p_bfly00_re),
    .p_bfly00_im (p_bfly00_im),
    .n_bfly00_re (n_bfly00_re),
    .n_bfly00_im (n_bfly00_im),
    .pair_idx    (pair_idx),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t ramp(input int c, input int off);
    vec_t v;
    for (int k = 0; k < LANES; k++) begin
      int s;
      s = c * LANES + k + off;
      if (s > 511) s = 511;
      v[k] = s[FIX-1:0];
    end
    return v;
  endfunction

  function automatic vec_t neg(input vec_t a);
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = ~a[k] + 10'd1;
    return v;
  endfunction

  function automatic vec_t fill(input int val);
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = val[FIX-1:0];
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int k = 0; k < LANES; k++) begin
      int r;
      r = int'($urandom_range(0, 254)) - 127;
      v[k] = r[FIX-1:0];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_beat  = 0;
    e_valid = 1'b0;
    e_done  = 1'b0;
    e_idx   = '0;
    e_pr = '0; e_pi = '0; e_nr = '0; e_ni = '0;
  endtask

  // Apply one cycle of input, advance the model at the edge, and sample 1 time unit later.
  task automatic drive(input bit v, input vec_t re, input vec_t im);
    in_valid = v;
    din_re   = re;
    din_im   = im;
    @(posedge clk);
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (v) begin
      for (int k = 0; k < LANES; k++) begin
        xr[m_beat*LANES+k] = re[k];
        xi[m_beat*LANES+k] = im[k];
      end
      if (m_beat >= DEPTH) begin
        int j;
        j = m_beat - DEPTH;
        e_valid = 1'b1;
        e_idx   = IDX_W'(j);
        e_done  = (j == DEPTH - 1);
        for (int k = 0; k < LANES; k++) begin
          e_pr[k] = xr[j*LANES+k];
          e_pi[k] = xi[j*LANES+k];
          e_nr[k] = xr[j*LANES+N+k];
          e_ni[k] = xi[j*LANES+N+k];
        end
      end
      m_beat = (m_beat + 1) % (2 * DEPTH);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    din_re = '0;
    din_im = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid, pair_idx, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: got v=%b idx=%0d done=%b, want all 0", valid, pair_idx, frame_done);
    end
    checks++;
    if ({p_bfly00_re, p_bfly00_im, n_bfly00_re, n_bfly00_im} !== '0) begin
      errors++;
      $display("FAIL reset_data: got p_re=%h n_re=%h, want 0", p_bfly00_re, n_bfly00_re);
    end
    rst = 1'b1;
  endtask

  task automatic test_ramp(input string name, input int off);
    for (int c = 0; c < 2 * DEPTH; c++) begin
      drive(1'b1, ramp(c, off), neg(ramp(c, off)));
      checks++;
      if ({valid, pair_idx, frame_done} !== {e_valid, e_idx, e_done}) begin
        errors++;
        $display("FAIL %s_ctl beat %0d: got v=%b idx=%0d done=%b, want v=%b idx=%0d done=%b",
                 name, c, valid, pair_idx, frame_done, e_valid, e_idx, e_done);
      end
      checks++;
      if ({p_bfly00_re, p_bfly00_im} !== {e_pr, e_pi}) begin
        errors++;
        $display("FAIL %s_p beat %0d: got %h want %h", name, c, {p_bfly00_re, p_bfly00_im}, {e_pr, e_pi});
      end
      checks++;
      if ({n_bfly00_re, n_bfly00_im} !== {e_nr, e_ni}) begin
        errors++;
        $display("FAIL %s_n beat %0d: got %h want %h", name, c, {n_bfly00_re, n_bfly00_im}, {e_nr, e_ni});
      end
    end
  endtask

  task automatic test_back_to_back();
    test_ramp("b2b_f0", 0);
    test_ramp("b2b_f1", 100);
  endtask

  task automatic test_gapped();
    int nxt = 0;
    for (int c = 0; c < 2 * DEPTH; c++) begin
      int gaps;
      gaps = (c == 3 || c == 15 || c == 16 || c == 30) ? 2 : 0;
      for (int g = 0; g <= gaps; g++) begin
        if (g == 0) drive(1'b1, ramp(c, 0), neg(ramp(c, 0)));
        else        drive(1'b0, '0, '0);
        checks++;
        if ({valid, pair_idx, frame_done} !== {e_valid, e_idx, e_done}) begin
          errors++;
          $display("FAIL gap_ctl beat %0d gap %0d: got v=%b idx=%0d done=%b, want v=%b idx=%0d done=%b",
                   c, g, valid, pair_idx, frame_done, e_valid, e_idx, e_done);
        end
        checks++;
        if ({p_bfly00_re, p_bfly00_im, n_bfly00_re} !== {e_pr, e_pi, e_nr}) begin
          errors++;
          $display("FAIL gap_data beat %0d gap %0d: got p_re=%h n_re=%h want p_re=%h n_re=%h",
                   c, g, p_bfly00_re, n_bfly00_re, e_pr, e_nr);
        end
        if (valid === 1'b1) begin
          checks++;
          if (pair_idx !== IDX_W'(nxt)) begin
            errors++;
            $display("FAIL gap_seq: got pair_idx=%0d want %0d", pair_idx, nxt);
          end
          nxt++;
        end
      end
    end
    checks++;
    if (nxt != DEPTH) begin
      errors++;
      $display("FAIL gap_count: got %0d pair beats want %0d", nxt, DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) drive(1'b1, ramp(c, 7), neg(ramp(c, 7)));
    rst = 1'b0;
    #1;
    for (int r = 0; r < 2; r++) begin
      checks++;
      if ({valid, pair_idx, frame_done} !== '0) begin
        errors++;
        $display("FAIL rstmid_ctl %0d: got v=%b idx=%0d done=%b, want all 0", r, valid, pair_idx, frame_done);
      end
      checks++;
      if ({p_bfly00_re, p_bfly00_im, n_bfly00_re, n_bfly00_im} !== '0) begin
        errors++;
        $display("FAIL rstmid_data %0d: got p_re=%h n_re=%h, want 0", r, p_bfly00_re, n_bfly00_re);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 2 * DEPTH; c++) begin
      drive(1'b1, ramp(c, 0), neg(ramp(c, 0)));
      checks++;
      if ({valid, pair_idx, frame_done, p_bfly00_re, n_bfly00_re} !== {e_valid, e_idx, e_done, e_pr, e_nr}) begin
        errors++;
        $display("FAIL rstmid_frame beat %0d: got v=%b idx=%0d p_re=%h n_re=%h want v=%b idx=%0d p_re=%h n_re=%h",
                 c, valid, pair_idx, p_bfly00_re, n_bfly00_re, e_valid, e_idx, e_pr, e_nr);
      end
      if (valid === 1'b1 && !seen) begin
        seen = 1'b1;
        checks++;
        if ($signed(p_bfly00_re[0]) != 0 || $signed(n_bfly00_re[0]) != 256) begin
          errors++;
          $display("FAIL rstmid_first: got p_re0=%0d n_re0=%0d want 0 256",
                   $signed(p_bfly00_re[0]), $signed(n_bfly00_re[0]));
        end
      end
    end
  endtask

  task automatic test_extremes();
    for (int c = 0; c < 2 * DEPTH; c++) begin
      if (c < DEPTH) drive(1'b1, fill(-512), fill(511));
      else           drive(1'b1, fill(511), fill(-512));
      checks++;
      if ({valid, pair_idx, frame_done} !== {e_valid, e_idx, e_done}) begin
        errors++;
        $display("FAIL ext_ctl beat %0d: got v=%b idx=%0d done=%b, want v=%b idx=%0d done=%b",
                 c, valid, pair_idx, frame_done, e_valid, e_idx, e_done);
      end
      if (c >= DEPTH) begin
        checks++;
        if ($signed(p_bfly00_re[5]) != -512 || $signed(p_bfly00_im[5]) != 511 ||
            $signed(n_bfly00_re[5]) != 511 || $signed(n_bfly00_im[5]) != -512) begin
          errors++;
          $display("FAIL ext_lane5 beat %0d: got p=%0d,%0d n=%0d,%0d want -512,511 511,-512", c,
                   $signed(p_bfly00_re[5]), $signed(p_bfly00_im[5]),
                   $signed(n_bfly00_re[5]), $signed(n_bfly00_im[5]));
        end
        checks++;
        if ({p_bfly00_re, p_bfly00_im, n_bfly00_re, n_bfly00_im} !== {e_pr, e_pi, e_nr, e_ni}) begin
          errors++;
          $display("FAIL ext_data beat %0d: got p_re=%h n_re=%h want p_re=%h n_re=%h",
                   c, p_bfly00_re, n_bfly00_re, e_pr, e_nr);
        end
      end
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    int vcount = 0;
    int cyc = 0;
    while (accepted < 4 * 2 * DEPTH && cyc < 2000) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      drive(v, rnd_vec(), rnd_vec());
      cyc++;
      if (v) accepted++;
      if (valid === 1'b1) vcount++;
      checks++;
      if ({valid, pair_idx, frame_done} !== {e_valid, e_idx, e_done}) begin
        errors++;
        $display("FAIL rnd_ctl cyc %0d: got v=%b idx=%0d done=%b, want v=%b idx=%0d done=%b",
                 cyc, valid, pair_idx, frame_done, e_valid, e_idx, e_done);
      end
      checks++;
      if ({p_bfly00_re, p_bfly00_im} !== {e_pr, e_pi}) begin
        errors++;
        $display("FAIL rnd_p cyc %0d: got %h want %h", cyc, {p_bfly00_re, p_bfly00_im}, {e_pr, e_pi});
      end
      checks++;
      if ({n_bfly00_re, n_bfly00_im} !== {e_nr, e_ni}) begin
        errors++;
        $display("FAIL rnd_n cyc %0d: got %h want %h", cyc, {n_bfly00_re, n_bfly00_im}, {e_nr, e_ni});
      end
    end
    checks++;
    if (vcount != 4 * DEPTH) begin
      errors++;
      $display("FAIL rnd_valid_count: got %0d want %0d", vcount, 4 * DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_ramp("ramp", 0);
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    test_extremes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_in_pair_buffer.md
Name: fft_in_pair_buffer

Overview:
- Front-end feeder for the first radix-2 DIF butterfly stage (step1) of the 512-point FFT.
- Accepts natural-order complex samples, LANES per clock, and buffers the first half-frame (N samples).
- While the second half-frame streams in, it emits aligned butterfly pairs: p = x[n] from the buffer, n = x[n+N] from the input.
- Output feeds step1 ports valid / p_bfly00_* / n_bfly00_* directly.

Parameters:
FIX, 10, signed sample width (re and im each)
LANES, 16, samples per clock per component
N, 256, butterfly span = half-frame length in samples; DEPTH = N/LANES = 16 cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  input lanes hold a valid beat
din_re  in  [0:LANES-1][FIX]  signed real samples, lane k = sample beat*LANES+k
din_im  in  [0:LANES-1][FIX]  signed imaginary samples
valid  out  1  output pair beat valid (drives step1 valid)
p_bfly00_re  out  [0:LANES-1][FIX]  x[n] real
p_bfly00_im  out  [0:LANES-1][FIX]  x[n] imag
n_bfly00_re  out  [0:LANES-1][FIX]  x[n+N] real
n_bfly00_im  out  [0:LANES-1][FIX]  x[n+N] imag
pair_idx  out  log2(DEPTH)  index j of the current output beat (0..DEPTH-1)
frame_done  out  1  one-cycle pulse with the last pair beat of a frame

Behaviour:
- Reset (rst=0, async): valid=0, frame_done=0, pair_idx=0, all p/n outputs=0, beat counter=0, state FILL. Buffer contents are don't-care and are not cleared.
- Beat counter cnt is log2(2*DEPTH) bits (5 at defaults). It advances only on in_valid=1 and wraps 2*DEPTH-1 -> 0.
- in_valid=0 stalls: counter and buffer hold; valid=0 on the next cycle. Gaps of any length are legal, and pairing stays aligned across them.
- State FILL (cnt < DEPTH):
  - On in_valid, write din_re/din_im into buf[cnt].
  - No output; valid=0.
- State PAIR (cnt >= DEPTH):
  - On in_valid, j = cnt-DEPTH.
  - Register p_*[k] <= buf[j][k] and n_*[k] <= din_*[k].
  - valid <= 1 and pair_idx <= j.
  - frame_done <= 1 iff j = DEPTH-1.
- Transitions:
  - FILL -> PAIR when a beat is accepted at cnt = DEPTH-1.
  - PAIR -> FILL when a beat is accepted at cnt = 2*DEPTH-1, with no idle cycle. The next accepted beat is beat 0 of the next frame.
- Latency: 1 clock from the accepted second-half beat to valid.
- Valid duty: DEPTH beats out per 2*DEPTH beats in.
- When valid=0, data outputs hold their last value. Consumers must qualify with valid.
- Widths: pure pass-through. No arithmetic, no growth, no saturation; bit-exact copy of the inputs.
- Simultaneous read/write: in PAIR, buf is only read, so there is no read/write hazard. Writes in FILL use a single address per cycle.
- Reset mid-frame discards the partial frame. The first beat after reset release is treated as x[0..LANES-1] of a new frame.

Decomposition:
- Shared package fft_pkg holds:
  - constants FIX, LANES, N, DEPTH
  - typedef sample_t = logic signed [FIX-1:0]
  - typedef lane_vec_t = sample_t [0:LANES-1]
  - enum feed_state_t {FILL, PAIR}
  - these are reused by step1 and later stages.
- Natural sub-module: fft_half_frame_buf, a DEPTH x (2*LANES*FIX) register array with write port (we, waddr, wdata) and registered read port (raddr, rdata). The top keeps the counter, FSM and output registers.

Test Plan:
- Ramp, no gaps:
  - Stimulus: beat c, lane k: re = c*16+k, im = -(c*16+k) for c = 0..31.
  - Required: valid low for beats 0..15, then high for 16 cycles starting 1 clk after beat 16.
  - Beat j: p_re[k] = j*16+k, n_re[k] = 256+j*16+k, im values negated.
  - frame_done high only at j = 15.
- Back-to-back frames: two ramp frames, the second offset by +100 (clamped to 511).
  - Required: valid pattern 16 low / 16 high repeating, and the second frame's pairs are correct.
- Gapped input: ramp with in_valid=0 inserted after beats 3, 15, 16 and 30 (2 cycles each).
  - Required: output values identical to the no-gap case.
  - valid=0 during each gap; pair_idx sequence 0..15 with no skips.
- Reset mid-operation: assert rst at beat 20, release, then send a fresh ramp.
  - Required: all outputs 0 and valid 0 while in reset.
  - The fresh frame's pairs are correct (p_re[0] of pair 0 = 0, n_re[0] = 256).
- Extremes: all lanes re = -512, im = 511 in the first half; re = 511, im = -512 in the second half.
  - Required: outputs reproduce exactly, with no sign corruption.
- Random: $random % 128 per lane for 4 frames, checked against a scoreboard model.
  - Required: zero mismatches; valid count = 64.
